j1_io_ctrl: RTL and testbench

J1_IO_CTRL -- requirements
Module: j1_io_ctrl

---
 rtl/j1_io_ctrl_pkg.sv | 32 +++
 rtl/j1_io_ctrl_if.sv | 40 ++++
 rtl/j1_io_timer.sv | 41 ++++
 rtl/j1_io_ctrl.sv | 124 ++++++++++++
 tb/tb_j1_io_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/j1_io_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : j1_io_ctrl_pkg
// Purpose  : Shared constants for the J1 I/O controller:
//            - FSM state encoding
//            - slot geometry and bus widths
//            - default timeout read data
//            - a slot-to-one-hot helper
// Revision : 1.0 - initial release
// ============================================================================
package j1_io_ctrl_pkg;

    localparam logic [1:0]  c_ST_IDLE   = 2'd0;
    localparam logic [1:0]  c_ST_ACCESS = 2'd1;
    localparam logic [1:0]  c_ST_DONE   = 2'd2;

    localparam int          c_SLOT_W    = 2;
    localparam int          c_SLOT_CNT  = 4;
    localparam int          c_DATA_W    = 16;
    localparam int          c_OFFS_W    = 14;

    localparam logic [15:0] c_ERR_DATA_DEFAULT = 16'hDEAD;

    function automatic logic [c_SLOT_CNT-1:0] slot_onehot(input logic [c_SLOT_W-1:0] slot);
        logic [c_SLOT_CNT-1:0] v;
        v       = '0;
        v[slot] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/j1_io_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : j1_io_ctrl_if
// Purpose  : CPU-side and peripheral-side signals of the J1 I/O controller.
//            master : the CPU / peripheral environment (drives requests,
//                     read buses, ready and err_clr)
//            slave  : the controller itself
// Revision : 1.0 - initial release
// ============================================================================
interface j1_io_ctrl_if;
    import j1_io_ctrl_pkg::*;

    logic                           cpu_rd;
    logic                           cpu_wr;
    logic [15:0]                    cpu_addr;
    logic [c_DATA_W-1:0]            cpu_dout;
    logic [c_DATA_W-1:0]            cpu_din;
    logic                           cpu_stall;
    logic [c_SLOT_CNT-1:0]          per_sel;
    logic                           per_rd;
    logic                           per_wr;
    logic [c_OFFS_W-1:0]            per_addr;
    logic [c_DATA_W-1:0]            per_wdata;
    logic [c_SLOT_CNT*c_DATA_W-1:0] per_rdata;
    logic [c_SLOT_CNT-1:0]          per_ready;
    logic                           err_flag;
    logic                           err_clr;

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_dout, per_rdata, per_ready, err_clr,
        input  cpu_din, cpu_stall, per_sel, per_rd, per_wr, per_addr, per_wdata, err_flag
    );

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_dout, per_rdata, per_ready, err_clr,
        output cpu_din, cpu_stall, per_sel, per_rd, per_wr, per_addr, per_wdata, err_flag
    );

endinterface
`default_nettype wire

// File: rtl/j1_io_timer.sv
`default_nettype none
// ============================================================================
// Module   : j1_io_timer
// Purpose  : Access wait counter with timeout compare.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            i_clear       - restart the count (access starting)
//            i_count_en    - an ACCESS cycle without ready
//            o_expired     - this cycle is the last allowed ACCESS cycle
// Revision : 1.0 - initial release
// ============================================================================
module j1_io_timer #(
    parameter int TIMEOUT = 15
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    input  wire logic i_count_en,
    output logic      o_expired
);

    // The counter holds the number of completed ready-less ACCESS cycles, so
    // the TIMEOUT-th cycle is the one that sees TIMEOUT-1; firing there makes
    // the counter reach TIMEOUT on the same edge that leaves ACCESS.
    localparam logic [7:0] c_LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_count_en) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_expired = i_count_en && (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/j1_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : j1_io_ctrl
// Purpose  : J1 CPU I/O access controller. Turns a held CPU read/write request
//            into a strobed access on one of four peripheral slots, stalls the
//            CPU until the slot reports ready, and aborts after TIMEOUT ACCESS
//            cycles with a sticky error (reads then return ERR_DATA).
// Ports    : sys_clk_i  - system clock
//            sys_rst_i  - synchronous active-high reset
//            bus        - j1_io_ctrl_if.slave (CPU request/response, peripheral
//                         select/strobes/address/data, ready, err flag/clear)
// Revision : 1.0 - initial release
// ============================================================================
module j1_io_ctrl
    import j1_io_ctrl_pkg::*;
#(
    parameter int          TIMEOUT  = 15,
    parameter logic [15:0] ERR_DATA = c_ERR_DATA_DEFAULT
) (
    input  wire logic       sys_clk_i,
    input  wire logic       sys_rst_i,
    j1_io_ctrl_if.slave     bus
);

    logic [1:0]          r_state;
    logic [1:0]          w_next;
    logic [c_SLOT_W-1:0] r_slot;
    logic [c_OFFS_W-1:0] r_offset;
    logic [c_DATA_W-1:0] r_wdata;
    logic                r_is_wr;
    logic [c_DATA_W-1:0] r_cpu_din;
    logic                r_err_flag;

    logic                w_req;
    logic                w_start;
    logic                w_in_access;
    logic                w_ready;
    logic                w_timeout;
    logic [c_DATA_W-1:0] w_rdata_sel;

    assign w_req       = bus.cpu_rd | bus.cpu_wr;
    assign w_start     = (r_state == c_ST_IDLE) && w_req;
    assign w_in_access = (r_state == c_ST_ACCESS);
    assign w_ready     = bus.per_ready[r_slot];

    // Ready gates the counter enable, so a timeout can never fire in a cycle
    // where the slot is ready: ready wins a coincidence by construction.
    j1_io_timer #(
        .TIMEOUT    (TIMEOUT)
    ) u_timer (
        .clk        (sys_clk_i),
        .rst        (sys_rst_i),
        .i_clear    (w_start),
        .i_count_en (w_in_access && !w_ready),
        .o_expired  (w_timeout)
    );

    // Read-data mux; its result is only captured in r_cpu_din.
    always_comb begin
        w_rdata_sel = '0;
        for (int i = 0; i < c_SLOT_CNT; i++) begin
            if (r_slot == i[c_SLOT_W-1:0]) begin
                w_rdata_sel = bus.per_rdata[i*c_DATA_W +: c_DATA_W];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_req)                 w_next = c_ST_ACCESS;
            c_ST_ACCESS: if (w_ready || w_timeout)  w_next = c_ST_DONE;
            c_ST_DONE:                              w_next = c_ST_IDLE;
            default:                                w_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_state    <= c_ST_IDLE;
            r_slot     <= '0;
            r_offset   <= '0;
            r_wdata    <= '0;
            r_is_wr    <= 1'b0;
            r_cpu_din  <= '0;
            r_err_flag <= 1'b0;
        end else begin
            r_state <= w_next;

            // Write takes precedence when both requests are raised together.
            if (w_start) begin
                r_slot   <= bus.cpu_addr[15:14];
                r_offset <= bus.cpu_addr[13:0];
                r_wdata  <= bus.cpu_dout;
                r_is_wr  <= bus.cpu_wr;
            end

            if (w_in_access && !r_is_wr) begin
                if (w_ready) begin
                    r_cpu_din <= w_rdata_sel;
                end else if (w_timeout) begin
                    r_cpu_din <= ERR_DATA;
                end
            end

            if (bus.err_clr) begin
                r_err_flag <= 1'b0;
            end else if (w_timeout) begin
                r_err_flag <= 1'b1;
            end
        end
    end

    assign bus.cpu_stall = w_start || w_in_access;
    assign bus.per_sel   = w_in_access ? slot_onehot(r_slot) : '0;
    assign bus.per_rd    = w_in_access && !r_is_wr;
    assign bus.per_wr    = w_in_access &&  r_is_wr;
    assign bus.per_addr  = r_offset;
    assign bus.per_wdata = r_wdata;
    assign bus.cpu_din   = r_cpu_din;
    assign bus.err_flag  = r_err_flag;

endmodule
`default_nettype wire

// File: tb/tb_j1_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_j1_io_ctrl
// Purpose  : Self-checking bench for j1_io_ctrl: directed vector table,
//            hand sequences for reset-in-access and back-to-back requests,
//            and randomized accesses against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_j1_io_ctrl;

    localparam int          TO  = 15;
    localparam logic [15:0] ERR = 16'hDEAD;

    logic clk;
    logic rst;

    j1_io_ctrl_if bus();

    j1_io_ctrl #(
        .TIMEOUT   (TO),
        .ERR_DATA  (ERR)
    ) dut (
        .sys_clk_i (clk),
        .sys_rst_i (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Transaction-level model state: what cpu_din / err_flag should hold
    // between accesses.
    logic [15:0] m_din;
    logic        m_err;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          ready_at;   // ACCESS cycle (1-based) ready rises; 0 = never
        int          clr_cycle;  // cycle index err_clr is high; -1 = none
        logic [3:0]  exp_sel;
        logic        exp_wr;
        int          exp_n;      // ACCESS cycles
        logic [15:0] exp_din;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] other_ready(input logic [1:0] slot);
        logic [3:0] r;
        logic [3:0] m;
        r = 4'($urandom);
        m = 4'b0001 << slot;
        return r & ~m;
    endfunction

    task automatic idle_cycle(input logic clr);
        @(negedge clk);
        bus.cpu_rd    = 1'b0;
        bus.cpu_wr    = 1'b0;
        bus.per_ready = 4'($urandom);
        bus.err_clr   = clr;
        #1;
        chk("idle_stall", {31'd0, bus.cpu_stall}, 32'd0);
        chk("idle_sel",   {28'd0, bus.per_sel},   32'd0);
        chk("idle_err",   {31'd0, bus.err_flag},  {31'd0, m_err});
        if (clr) m_err = 1'b0;
    endtask

    // Cycle 0 is the IDLE cycle presenting the request, cycles 1..exp_n are
    // ACCESS, then one DONE cycle with the request still held.
    task automatic run_access(input logic rd, input logic wr, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic [15:0] rdata,
                              input int ready_at, input int clr_cycle,
                              input logic [3:0] exp_sel, input logic exp_wr,
                              input int exp_n, input logic [15:0] exp_din,
                              input logic exp_err);
        logic [1:0]  slot;
        logic [63:0] rbus;
        logic        e_err;
        logic [3:0]  rdy;
        slot = addr[15:14];
        rbus = {$urandom, $urandom};
        rbus[slot*16 +: 16] = rdata;
        e_err = m_err;

        @(negedge clk);
        bus.cpu_rd    = rd;
        bus.cpu_wr    = wr;
        bus.cpu_addr  = addr;
        bus.cpu_dout  = wdata;
        bus.per_rdata = rbus;
        bus.per_ready = other_ready(slot);
        bus.err_clr   = (clr_cycle == 0);
        #1;
        chk("req_stall",  {31'd0, bus.cpu_stall}, 32'd1);
        chk("req_sel",    {28'd0, bus.per_sel},   32'd0);
        chk("req_strobe", {30'd0, bus.per_rd, bus.per_wr}, 32'd0);
        chk("req_err",    {31'd0, bus.err_flag},  {31'd0, e_err});
        if (clr_cycle == 0) e_err = 1'b0;

        for (int k = 1; k <= exp_n; k++) begin
            @(negedge clk);
            rdy = other_ready(slot);
            if (ready_at > 0 && k >= ready_at) rdy[slot] = 1'b1;
            bus.per_ready = rdy;
            bus.err_clr   = (clr_cycle == k);
            #1;
            chk("acc_stall", {31'd0, bus.cpu_stall}, 32'd1);
            chk("acc_sel",   {28'd0, bus.per_sel},   {28'd0, exp_sel});
            chk("acc_rd",    {31'd0, bus.per_rd},    {31'd0, !exp_wr});
            chk("acc_wr",    {31'd0, bus.per_wr},    {31'd0, exp_wr});
            chk("acc_addr",  {18'd0, bus.per_addr},  {18'd0, addr[13:0]});
            chk("acc_wdata", {16'd0, bus.per_wdata}, {16'd0, wdata});
            chk("acc_din",   {16'd0, bus.cpu_din},   {16'd0, m_din});
            chk("acc_err",   {31'd0, bus.err_flag},  {31'd0, e_err});
            if (clr_cycle == k) e_err = 1'b0;
        end

        @(negedge clk);
        bus.per_ready = 4'($urandom);
        bus.err_clr   = 1'b0;
        #1;
        chk("done_stall",  {31'd0, bus.cpu_stall}, 32'd0);
        chk("done_sel",    {28'd0, bus.per_sel},   32'd0);
        chk("done_strobe", {30'd0, bus.per_rd, bus.per_wr}, 32'd0);
        chk("done_din",    {16'd0, bus.cpu_din},   {16'd0, exp_din});
        chk("done_err",    {31'd0, bus.err_flag},  {31'd0, exp_err});
        m_din = exp_din;
        m_err = exp_err;
    endtask

    function automatic int acc_len(input int ready_at);
        return (ready_at >= 1 && ready_at <= TO) ? ready_at : TO;
    endfunction

    // Reference model: derives the outcome of one access from its inputs.
    task automatic model_access(input logic rd, input logic wr, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [15:0] rdata,
                                input int ready_at, input int clr_cycle);
        int          n;
        logic        timed_out;
        logic [15:0] e_din;
        logic        e_err;
        logic [3:0]  e_sel;
        n         = acc_len(ready_at);
        timed_out = !(ready_at >= 1 && ready_at <= TO);
        e_din     = wr ? m_din : (timed_out ? ERR : rdata);
        e_err     = m_err;
        if (clr_cycle >= 0 && clr_cycle <= n) e_err = 1'b0;
        if (timed_out && clr_cycle != n)      e_err = 1'b1;
        e_sel     = 4'b0001 << addr[15:14];
        run_access(rd, wr, addr, wdata, rdata, ready_at, clr_cycle, e_sel, wr, n, e_din, e_err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_din    = 16'h0000;
        m_err    = 1'b0;

        //        rd    wr    addr      wdata     rdata     rdy clr  sel      wr    n   din       err
        vecs[0] = '{1'b1, 1'b0, 16'h4005, 16'h0000, 16'h1234, 1,  -1, 4'b0010, 1'b0, 1,  16'h1234, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 16'hC010, 16'hBEEF, 16'h0000, 4,  -1, 4'b1000, 1'b1, 4,  16'h1234, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 16'h8123, 16'h0000, 16'h4321, 0,  -1, 4'b0100, 1'b0, 15, 16'hDEAD, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 16'h0042, 16'h0000, 16'h5A5A, 15,  0, 4'b0001, 1'b0, 15, 16'h5A5A, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 16'h4777, 16'h0F0F, 16'h7777, 2,  -1, 4'b0010, 1'b1, 2,  16'h5A5A, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 16'h7FFF, 16'h0000, 16'h2468, 16, 15, 4'b0010, 1'b0, 15, 16'hDEAD, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 16'h0001, 16'h1111, 16'h0000, 0,  -1, 4'b0001, 1'b1, 15, 16'hDEAD, 1'b1};

        rst           = 1'b1;
        bus.cpu_rd    = 1'b0;
        bus.cpu_wr    = 1'b0;
        bus.cpu_addr  = 16'h0000;
        bus.cpu_dout  = 16'h0000;
        bus.per_rdata = '0;
        bus.per_ready = 4'b0000;
        bus.err_clr   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_din",   {16'd0, bus.cpu_din},   32'd0);
        chk("rst_err",   {31'd0, bus.err_flag},  32'd0);
        chk("rst_sel",   {28'd0, bus.per_sel},   32'd0);
        chk("rst_addr",  {18'd0, bus.per_addr},  32'd0);
        chk("rst_wdata", {16'd0, bus.per_wdata}, 32'd0);
        chk("rst_stall", {31'd0, bus.cpu_stall}, 32'd0);
        rst = 1'b0;
        idle_cycle(1'b0);

        for (int i = 0; i < 7; i++) begin
            run_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                       vecs[i].ready_at, vecs[i].clr_cycle, vecs[i].exp_sel, vecs[i].exp_wr,
                       vecs[i].exp_n, vecs[i].exp_din, vecs[i].exp_err);
            idle_cycle(1'b0);
        end

        // Reset on the second ACCESS cycle of a read, with err_flag set.
        @(negedge clk);
        bus.cpu_rd    = 1'b1;
        bus.cpu_wr    = 1'b0;
        bus.cpu_addr  = 16'h4005;
        bus.per_ready = 4'b0000;
        #1;
        chk("rsta_stall", {31'd0, bus.cpu_stall}, 32'd1);
        @(negedge clk);
        #1;
        chk("rsta_sel1", {28'd0, bus.per_sel}, 32'd2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rsta_sel2", {28'd0, bus.per_sel}, 32'd2);
        @(negedge clk);
        rst        = 1'b0;
        bus.cpu_rd = 1'b0;
        #1;
        chk("rsta_sel",    {28'd0, bus.per_sel},   32'd0);
        chk("rsta_strobe", {30'd0, bus.per_rd, bus.per_wr}, 32'd0);
        chk("rsta_err",    {31'd0, bus.err_flag},  32'd0);
        chk("rsta_din",    {16'd0, bus.cpu_din},   32'd0);
        chk("rsta_stall",  {31'd0, bus.cpu_stall}, 32'd0);
        m_din = 16'h0000;
        m_err = 1'b0;
        idle_cycle(1'b0);

        // Back-to-back reads with the request held continuously.
        model_access(1'b1, 1'b0, 16'h4005, 16'h0000, 16'hA1A1, 1, -1);
        model_access(1'b1, 1'b0, 16'h4005, 16'h0000, 16'hB2B2, 2, -1);
        idle_cycle(1'b0);

        for (int i = 0; i < 150; i++) begin
            logic        r_rd;
            logic        r_wr;
            int          mode;
            int          rdy;
            int          clr;
            mode = int'($urandom_range(0, 2));
            r_rd = (mode != 1);
            r_wr = (mode != 0);
            rdy  = int'($urandom_range(0, 17));
            clr  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, acc_len(rdy))) : -1;
            model_access(r_rd, r_wr, 16'($urandom), 16'($urandom), 16'($urandom), rdy, clr);
            if ($urandom_range(0, 1) == 1) idle_cycle($urandom_range(0, 4) == 0);
        end

        idle_cycle(1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
